// File: rtl/geom_mem_arbiter.sv
// geom_mem_arbiter: shares one single-port geometry RAM between a write
// requester (SPI loader) and a read requester (frame driver).
// Ownership is sticky so bursts run back-to-back. Reads win a tie from idle.
// A saturating wait counter per side lets a starved requester preempt the owner.
// Read data returns RD_LAT cycles after issue, flagged by rd_valid.
// Optional feature macro: GEOM_ARB_STATS_EN adds saturating 16-bit access and
// conflict counters (stat_rd_cnt, stat_wr_cnt, stat_conflict_cnt).
module geom_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 108,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef GEOM_ARB_STATS_EN
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_conflict_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_RD = 2'd1,
    OWN_WR = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        rd_wait;
  logic [7:0]        wr_wait;
  logic              rd_sel;
  logic              wr_sel;
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT:0]   vld_ext;
  logic [RD_LAT-1:0] vld_nxt;
  logic              mem_rd;

  // Waiting counter: counts denied cycles, saturates, clears on grant or drop.
  function automatic logic [7:0] wait_next(input logic req, input logic gnt,
                                           input logic [7:0] cnt);
    if (!req || gnt)
      return 8'd0;
    else if (cnt == WAIT_MAX)
      return cnt;
    else
      return cnt + 8'd1;
  endfunction

  // Grant decision: sticky owner, read wins from idle, starved side preempts.
  always_comb begin
    rd_sel = 1'b0;
    wr_sel = 1'b0;
    if (!rst) begin
      if (rd_req && wr_req) begin
        unique case (state)
          OWN_RD: begin
            if (wr_wait == WAIT_MAX) wr_sel = 1'b1;
            else                     rd_sel = 1'b1;
          end
          OWN_WR: begin
            if (rd_wait == WAIT_MAX) rd_sel = 1'b1;
            else                     wr_sel = 1'b1;
          end
          default: rd_sel = 1'b1;
        endcase
      end else if (rd_req) begin
        rd_sel = 1'b1;
      end else if (wr_req) begin
        wr_sel = 1'b1;
      end
    end
    if (rd_sel)      state_nxt = OWN_RD;
    else if (wr_sel) state_nxt = OWN_WR;
    else             state_nxt = NONE;
  end

  assign rd_gnt = rd_sel;
  assign wr_gnt = wr_sel;

  // Next content of the read-valid pipe: shift in reads currently on the RAM port.
  assign mem_rd  = mem_en & ~mem_we;
  assign vld_ext = {vld_p, mem_rd};
  assign vld_nxt = vld_ext[RD_LAT-1:0];

  // Owner FSM with registered RAM issue, wait counters and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NONE;
      rd_wait   <= 8'd0;
      wr_wait   <= 8'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_wait <= wait_next(rd_req, rd_sel, rd_wait);
      wr_wait <= wait_next(wr_req, wr_sel, wr_wait);
      mem_en  <= rd_sel | wr_sel;
      mem_we  <= wr_sel;
      if (wr_sel) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (rd_sel) begin
        mem_addr  <= rd_addr;
      end
      busy <= (state_nxt != NONE) || (|vld_nxt);
    end
  end

  // Read-return valid pipe; reset discards every read in flight.
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else     vld_p <= vld_nxt;
  end

  assign rd_valid = vld_p[RD_LAT-1];
  assign rd_data  = mem_rdata;

`ifdef GEOM_ARB_STATS_EN
  // Saturating 16-bit event counter increment.
  function automatic logic [15:0] sat_inc(input logic ev, input logic [15:0] cnt);
    if (ev && cnt != 16'hFFFF) return cnt + 16'd1;
    else                       return cnt;
  endfunction

  // Access and conflict statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt       <= 16'd0;
      stat_wr_cnt       <= 16'd0;
      stat_conflict_cnt <= 16'd0;
    end else begin
      stat_rd_cnt       <= sat_inc(rd_sel, stat_rd_cnt);
      stat_wr_cnt       <= sat_inc(wr_sel, stat_wr_cnt);
      stat_conflict_cnt <= sat_inc(rd_req & wr_req, stat_conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_geom_mem_arbiter.sv
// Directed testbench for geom_mem_arbiter (default parameters, RD_LAT=2,
// MAX_WAIT=8) with a behavioural single-port RAM of matching latency.
module tb_geom_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 108;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
`ifdef GEOM_ARB_STATS_EN
  logic [15:0]       stat_rd_cnt;
  logic [15:0]       stat_wr_cnt;
  logic [15:0]       stat_conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  geom_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef GEOM_ARB_STATS_EN
    .stat_rd_cnt       (stat_rd_cnt),
    .stat_wr_cnt       (stat_wr_cnt),
    .stat_conflict_cnt (stat_conflict_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on issue, read data visible two cycles after issue.
  logic [DATA_W-1:0] ram [0:8191];
  logic [DATA_W-1:0] rd_p0 = '0;
  logic [DATA_W-1:0] rd_p1 = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rd_p0 <= ram[mem_addr];
    end
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[13'h200 + i] = 108'h5000 + 108'(i);
    ram[13'h0010] = 108'h0123_4567_89AB_CDEF;
    ram[13'h0033] = 108'h0DEAD;

    // Reset with both requests high: no grant may leak out.
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 13'h0077; wr_addr = 13'h0066; wr_data = 108'h99;
    repeat (3) tick();
    #1;
    chk("rst_rd_gnt", 128'(rd_gnt), 128'd0);
    chk("rst_wr_gnt", 128'(wr_gnt), 128'd0);
    chk("rst_mem_en", 128'(mem_en), 128'd0);
    chk("rst_mem_we", 128'(mem_we), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_mem_wdata", 128'(mem_wdata), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    tick();
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    tick();

    // Single read of 13'h0010.
    rd_req = 1'b1; rd_addr = 13'h0010; #1;
    chk("rd1_gnt", 128'(rd_gnt), 128'd1);
    chk("rd1_wr_gnt", 128'(wr_gnt), 128'd0);
    tick(); rd_req = 1'b0; #1;
    chk("rd1_mem_en", 128'(mem_en), 128'd1);
    chk("rd1_mem_we", 128'(mem_we), 128'd0);
    chk("rd1_mem_addr", 128'(mem_addr), 128'h10);
    chk("rd1_busy", 128'(busy), 128'd1);
    chk("rd1_valid_n1", 128'(rd_valid), 128'd0);
    tick(); #1;
    chk("rd1_valid_n2", 128'(rd_valid), 128'd0);
    chk("rd1_mem_en_n2", 128'(mem_en), 128'd0);
    tick(); #1;
    chk("rd1_valid_n3", 128'(rd_valid), 128'd1);
    chk("rd1_data", 128'(rd_data), 128'h0123_4567_89AB_CDEF);
    chk("rd1_busy_n3", 128'(busy), 128'd1);
    tick(); #1;
    chk("rd1_valid_n4", 128'(rd_valid), 128'd0);
    chk("rd1_busy_n4", 128'(busy), 128'd0);

    // Write then read of the same address on the next cycle.
    tick();
    wr_req = 1'b1; wr_addr = 13'h0005; wr_data = 108'hABC; #1;
    chk("wr_gnt", 128'(wr_gnt), 128'd1);
    chk("wr_rd_gnt", 128'(rd_gnt), 128'd0);
    tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 13'h0005; #1;
    chk("raw_rd_gnt", 128'(rd_gnt), 128'd1);
    chk("raw_wr_mem_en", 128'(mem_en), 128'd1);
    chk("raw_wr_mem_we", 128'(mem_we), 128'd1);
    chk("raw_wr_mem_addr", 128'(mem_addr), 128'h5);
    chk("raw_wr_mem_wdata", 128'(mem_wdata), 128'hABC);
    tick(); rd_req = 1'b0; #1;
    chk("raw_rd_mem_en", 128'(mem_en), 128'd1);
    chk("raw_rd_mem_we", 128'(mem_we), 128'd0);
    chk("raw_rd_mem_addr", 128'(mem_addr), 128'h5);
    tick(); #1;
    chk("raw_valid_early", 128'(rd_valid), 128'd0);
    tick(); #1;
    chk("raw_valid", 128'(rd_valid), 128'd1);
    chk("raw_data", 128'(rd_data), 128'hABC);
    repeat (3) tick();

    // Both requesters held high from idle: 8 reads, 8 writes, then reads.
    rd_req = 1'b1; rd_addr = 13'h0300; wr_req = 1'b1; wr_addr = 13'h0100; wr_data = 108'h77;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("starve_rd_gnt_c%0d", c), 128'(rd_gnt), 128'((c < 8) || (c >= 16)));
      chk($sformatf("starve_wr_gnt_c%0d", c), 128'(wr_gnt), 128'((c >= 8) && (c < 16)));
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (6) tick();
    #1;
    chk("starve_idle_busy", 128'(busy), 128'd0);

    // 20 back-to-back reads give 20 gapless rd_valid pulses.
    tick();
    for (int c = 0; c < 26; c++) begin
      rd_req = (c < 20);
      rd_addr = 13'h0200 + 13'(c);
      #1;
      if (c < 20) chk($sformatf("b2b_gnt_c%0d", c), 128'(rd_gnt), 128'd1);
      chk($sformatf("b2b_wr_gnt_c%0d", c), 128'(wr_gnt), 128'd0);
      chk($sformatf("b2b_valid_c%0d", c), 128'(rd_valid), 128'((c >= 3) && (c < 23)));
      if (c >= 3 && c < 23)
        chk($sformatf("b2b_data_c%0d", c), 128'(rd_data), 128'h5000 + 128'(c - 3));
      tick();
    end

    // Reset one cycle after a read is issued: the read never returns.
    rd_req = 1'b1; rd_addr = 13'h0033; #1;
    chk("rstmid_gnt", 128'(rd_gnt), 128'd1);
    tick(); rd_req = 1'b0; #1;
    chk("rstmid_issue", 128'(mem_en), 128'd1);
    tick(); rst = 1'b1; rd_req = 1'b1; #1;
    chk("rstmid_gnt_gated", 128'(rd_gnt), 128'd0);
    tick(); rst = 1'b0; rd_req = 1'b0; #1;
    chk("rstmid_mem_en", 128'(mem_en), 128'd0);
    chk("rstmid_mem_we", 128'(mem_we), 128'd0);
    chk("rstmid_mem_addr", 128'(mem_addr), 128'd0);
    chk("rstmid_mem_wdata", 128'(mem_wdata), 128'd0);
    chk("rstmid_busy", 128'(busy), 128'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rstmid_no_valid_%0d", c), 128'(rd_valid), 128'd0);
      tick();
    end

`ifdef GEOM_ARB_STATS_EN
    // Three conflict cycles (all reads granted) plus two lone reads.
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 13'h0201;
    repeat (3) tick();
    wr_req = 1'b0;
    repeat (2) tick();
    rd_req = 1'b0;
    tick(); #1;
    chk("stat_conflict", 128'(stat_conflict_cnt), 128'd3);
    chk("stat_rd", 128'(stat_rd_cnt), 128'd5);
    chk("stat_wr", 128'(stat_wr_cnt), 128'd0);
    repeat (4) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
